// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, defaults and helpers for the serial pattern detector
package seq_det_pkg;

   localparam int PAT_W_DEF = 4;
   localparam int CNT_W_DEF = 8;

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_ARMED = 1'b1
   } det_state_e;

   // Width needed to hold a fill count of 0..pat_w inclusive.
   function automatic int fill_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with sticky overflow flag and synchronous clear
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         sat
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   // Clear has priority over a simultaneous increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (inc) begin
         if (cnt != CNT_MAX) begin
            cnt <= cnt + W'(1);
         end else begin
            sat <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - loadable serial bit-pattern detector with match pulse and saturating count
module seq_detect_param
   import seq_det_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in,
   input  logic             en,
   input  logic             load,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   input  logic             clr,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt,
   output logic             sat
);

   localparam int            FW   = fill_w(PAT_W);
   localparam logic [FW-1:0] FULL = FW'(PAT_W);

   logic [PAT_W-1:0] pat_q, pat_n;
   logic [PAT_W-1:0] hist, hist_n;
   logic [PAT_W-1:0] shifted;
   logic [FW-1:0]    fill, fill_n;
   det_state_e       state, state_n;
   logic             hit;

   assign shifted = {hist[PAT_W-2:0], in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q <= '0;
         hist  <= '0;
         fill  <= '0;
         state <= ST_FILL;
         out   <= 1'b0;
      end else begin
         pat_q <= pat_n;
         hist  <= hist_n;
         fill  <= fill_n;
         state <= state_n;
         out   <= hit;
      end
   end

   always_comb begin
      pat_n   = pat_q;
      hist_n  = hist;
      fill_n  = fill;
      state_n = state;
      hit     = 1'b0;
      if (load) begin
         // The bit presented alongside load is dropped; detection restarts from empty.
         pat_n   = pattern;
         fill_n  = '0;
         state_n = ST_FILL;
      end else if (en) begin
         hist_n = shifted;
         hit    = ((state == ST_ARMED) || (fill == FULL - FW'(1))) && (shifted == pat_q);
         if (hit && !overlap) begin
            fill_n = '0;
         end else if (state == ST_ARMED) begin
            fill_n = FULL;
         end else begin
            fill_n = fill + FW'(1);
         end
         state_n = (fill_n == FULL) ? ST_ARMED : ST_FILL;
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .inc  (hit),
      .cnt  (match_cnt),
      .sat  (sat)
   );

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for the serial pattern detector
module tb_seq_detect_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_b = 1'b0;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [3:0] pattern = 4'b0000;
   logic       overlap = 1'b1;
   logic       clr = 1'b0;
   logic       out;
   logic [1:0] match_cnt;
   logic       sat;

   typedef struct {
      int         id;
      logic [1:0] cnt;
      logic       sat;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   stim_id = 0;

   always #5 clk = ~clk;

   seq_detect_param #(
      .PAT_W(4),
      .CNT_W(2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in_b),
      .en       (en),
      .load     (load),
      .pattern  (pattern),
      .overlap  (overlap),
      .clr      (clr),
      .out      (out),
      .match_cnt(match_cnt),
      .sat      (sat)
   );

   // Monitor: every pulse must correspond to the oldest expected match.
   always @(negedge clk) begin
      if (rst_n && out) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse at stim %0d cnt=%0d sat=%0d", stim_id, match_cnt, sat);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.id != stim_id || e.cnt != match_cnt || e.sat != sat) begin
               errors++;
               $display("FAIL pulse got stim=%0d cnt=%0d sat=%0d expected stim=%0d cnt=%0d sat=%0d",
                        stim_id, match_cnt, sat, e.id, e.cnt, e.sat);
            end
         end
      end
   end

   task automatic step(input logic b_in, input logic b_en, input logic b_load,
                       input logic [3:0] b_pat, input logic b_clr,
                       input logic exp_p, input logic [1:0] exp_cnt, input logic exp_sat);
      exp_t e;
      @(negedge clk);
      #1;
      in_b    = b_in;
      en      = b_en;
      load    = b_load;
      pattern = b_pat;
      clr     = b_clr;
      stim_id++;
      if (exp_p) begin
         e.id  = stim_id;
         e.cnt = exp_cnt;
         e.sat = exp_sat;
         q.push_back(e);
      end
   endtask

   task automatic bit_in(input logic b, input logic exp_p, input logic [1:0] exp_cnt, input logic exp_sat);
      step(b, 1'b1, 1'b0, 4'b0000, 1'b0, exp_p, exp_cnt, exp_sat);
   endtask

   task automatic load_pat(input logic [3:0] p);
      step(1'b1, 1'b1, 1'b1, p, 1'b0, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic settle();
      step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
   endtask

   task automatic clear();
      step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp_v);
      end
   endtask

   initial begin
      #12;
      chk("reset_out", out, 0);
      chk("reset_cnt", match_cnt, 0);
      chk("reset_sat", sat, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Overlapping 1010 over 101010: hits on bits 4 and 6.
      overlap = 1'b1;
      load_pat(4'b1010);
      bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0);
      bit_in(0, 1, 1, 0); bit_in(1, 0, 0, 0); bit_in(0, 1, 2, 0);
      settle();
      chk("ovl_cnt", match_cnt, 2);
      clear();
      settle();

      // Non-overlapping: bits 5-6 only refill.
      overlap = 1'b0;
      load_pat(4'b1010);
      bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0);
      bit_in(0, 1, 1, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0);
      settle();
      chk("novl_cnt", match_cnt, 1);
      clear();

      // Enable gap is transparent to history.
      overlap = 1'b1;
      load_pat(4'b1010);
      bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
      bit_in(1, 0, 0, 0); bit_in(0, 1, 1, 0);
      settle();
      chk("gap_cnt", match_cnt, 1);
      clear();

      // Saturation with a 2-bit counter.
      load_pat(4'b1111);
      for (int i = 0; i < 3; i++) bit_in(1, 0, 0, 0);
      bit_in(1, 1, 1, 0); bit_in(1, 1, 2, 0); bit_in(1, 1, 3, 0); bit_in(1, 1, 3, 1);
      settle();
      chk("sat_cnt", match_cnt, 3);
      chk("sat_flag", sat, 1);
      clear();
      settle();
      chk("clr_cnt", match_cnt, 0);
      chk("clr_sat", sat, 0);

      // Clear coincident with a hit: pulse still occurs, count stays 0.
      load_pat(4'b1111);
      for (int i = 0; i < 3; i++) bit_in(1, 0, 0, 0);
      step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
      settle();
      chk("clrhit_cnt", match_cnt, 0);

      // Reload mid-stream discards the concurrent bit and restarts fill.
      load_pat(4'b1010);
      bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0);
      step(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 2'd0, 1'b0);
      bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 1, 1, 0);
      settle();
      chk("reload_cnt", match_cnt, 1);

      // Asynchronous reset mid-pattern.
      load_pat(4'b1010);
      bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0);
      @(negedge clk);
      #1 en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out", out, 0);
      chk("arst_cnt", match_cnt, 0);
      chk("arst_sat", sat, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      bit_in(0, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(0, 1, 1, 0);
      settle();
      chk("post_rst_cnt", match_cnt, 1);

      chk("missing_pulses", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
